// File: rtl/fluid_recv_fifo.sv
// Fluid (valid/retry) receiver with a small elastic FIFO, occupancy and token counters.
// Optional zero-latency empty-path bypass when FLUID_RECV_BYPASS_EN is defined.
module fluid_recv_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_retry,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_retry,
  output logic [WIDTH-1:0] out_data,
  output logic [AW:0]      count,
  output logic [15:0]      tokens_rcvd
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   tok_q, tok_d;

  logic full;
  logic empty;
  logic byp;
  logic push;
  logic pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Bypass is gated by reset so out_valid stays low while held in reset.
`ifdef FLUID_RECV_BYPASS_EN
  assign byp = reset_n & empty & in_valid & ~out_retry;
`else
  assign byp = 1'b0;
`endif

  assign push = in_valid & ~full & ~byp;
  assign pop  = ~empty & ~out_retry;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    tok_d    = tok_q;
    if (push)
      wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)
      rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (push | byp)
      tok_d = tok_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tok_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tok_q    <= tok_d;
    end
  end

  // Storage is left unreset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= in_data;
  end

  assign in_retry    = full;
  assign out_valid   = ~empty | byp;
  assign out_data    = byp ? in_data : mem_q[rd_ptr_q];
  assign count       = count_q;
  assign tokens_rcvd = tok_q;

endmodule

// File: tb/tb_fluid_recv_fifo.sv
// Randomized self-checking bench for fluid_recv_fifo.
// Reference model is a token queue plus a wrapping push counter.
module tb_fluid_recv_fifo;

  localparam int WIDTH = 3;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);
`ifdef FLUID_RECV_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_retry;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_retry;
  logic [WIDTH-1:0] out_data;
  logic [AW:0]      count;
  logic [15:0]      tokens_rcvd;

  fluid_recv_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_retry(in_retry),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_retry(out_retry),
    .out_data(out_data),
    .count(count),
    .tokens_rcvd(tokens_rcvd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] q_m [$];
  logic [WIDTH-1:0] log_m [$];
  logic [15:0]      tok_m;
  bit               pend;
  logic             last_ov;
  logic [WIDTH-1:0] last_od;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_data   = '1;
    out_retry = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_retry", 32'(in_retry), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_tokens", 32'(tokens_rcvd), 0);
    @(posedge clk); #1;
    chk("rst_hold_count", 32'(count), 0);
    chk("rst_hold_valid", 32'(out_valid), 0);
    @(negedge clk);
    reset_n  = 1'b1;
    in_valid = 1'b0;
    q_m.delete();
    log_m.delete();
    tok_m = '0;
    pend  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic cycle(input logic v, input logic [WIDTH-1:0] d,
                       input logic r);
    bit byp, eov, eir, pu, po;
    logic [WIDTH-1:0] eod;
    in_valid  = v;
    in_data   = d;
    out_retry = r;
    @(negedge clk);
    byp = BYP && (q_m.size() == 0) && v && !r;
    eov = (q_m.size() != 0) || byp;
    eir = (q_m.size() == DEPTH);
    chk("out_valid", 32'(out_valid), 32'(eov));
    chk("in_retry", 32'(in_retry), 32'(eir));
    chk("count", 32'(count), 32'(q_m.size()));
    chk("tokens_rcvd", 32'(tokens_rcvd), 32'(tok_m));
    if (eov) begin
      eod = byp ? d : q_m[0];
      chk("out_data", 32'(out_data), 32'(eod));
    end
    last_ov = out_valid;
    last_od = out_data;
    pu = v && !eir;
    po = eov && !r;
    if (po) log_m.push_back(out_data);
    if (pu) tok_m = tok_m + 16'd1;
    if (!byp) begin
      if (po) void'(q_m.pop_front());
      if (pu) q_m.push_back(d);
    end
    pend = v && !pu;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [WIDTH-1:0] exp_seq [5];
    logic v, r;
    logic [WIDTH-1:0] d;
    exp_seq[0] = 3'h1;
    exp_seq[1] = 3'h2;
    exp_seq[2] = 3'h3;
    exp_seq[3] = 3'h4;
    exp_seq[4] = 3'h7;

    reset_n   = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_retry = 1'b0;
    #1;
    do_reset();

    // first token, one cycle to presentation
    cycle(1'b1, 3'h5, BYP);
    if (!BYP) chk("lat_same_cycle", 32'(last_ov), 0);
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_data", 32'(out_data), 32'h5);
    cycle(1'b0, 3'h0, 1'b0);
    chk("lat_drained", 32'(count), 0);

    // fill to full with a held fifth token
    do_reset();
    cycle(1'b1, 3'h1, 1'b1);
    cycle(1'b1, 3'h2, 1'b1);
    cycle(1'b1, 3'h3, 1'b1);
    cycle(1'b1, 3'h4, 1'b1);
    chk("fill_count", 32'(count), 4);
    chk("fill_retry", 32'(in_retry), 1);
    cycle(1'b1, 3'h7, 1'b1);
    cycle(1'b1, 3'h7, 1'b1);
    chk("full_count", 32'(count), 4);
    chk("full_tokens", 32'(tokens_rcvd), 4);

    // drain from full
    log_m.delete();
    cycle(1'b1, 3'h7, 1'b0);
    chk("drain_retry_drop", 32'(in_retry), 0);
    cycle(1'b1, 3'h7, 1'b0);
    repeat (3) cycle(1'b0, 3'h0, 1'b0);
    chk("drain_count", 32'(count), 0);
    chk("drain_pops", 32'(log_m.size()), 5);
    for (int i = 0; i < 5 && i < log_m.size(); i++)
      chk("drain_order", 32'(log_m[i]), 32'(exp_seq[i]));

    // reset with tokens in flight
    cycle(1'b1, 3'h2, 1'b1);
    cycle(1'b1, 3'h3, 1'b1);
    do_reset();

    // streaming
    for (int i = 0; i < 20; i++)
      cycle(1'b1, WIDTH'(i), 1'b0);
    chk("stream_tokens", 32'(tokens_rcvd), 20);
    chk("stream_count", 32'(count), BYP ? 0 : 1);
    cycle(1'b0, 3'h0, 1'b0);

`ifdef FLUID_RECV_BYPASS_EN
    cycle(1'b1, 3'h6, 1'b0);
    chk("byp_valid", 32'(last_ov), 1);
    chk("byp_data", 32'(last_od), 32'h6);
    chk("byp_count", 32'(count), 0);
    chk("byp_tokens", 32'(tokens_rcvd), 21);
    cycle(1'b1, 3'h6, 1'b1);
    chk("byp_retry_count", 32'(count), 1);
    cycle(1'b0, 3'h0, 1'b0);
`endif

    // random backpressure, long enough to wrap tokens_rcvd
    for (int i = 0; i < 72000; i++) begin
      if (i < 68000) begin
        v = ($urandom % 64) != 0;
        r = ($urandom % 64) == 0;
      end else begin
        v = 1'(($urandom % 2));
        r = 1'(($urandom % 2));
      end
      d = WIDTH'($urandom);
      if (pend) begin
        v = 1'b1;
        d = in_data;
      end
      cycle(v, d, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
